// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared definitions for the data-memory / MMIO bridge.
// Holds the MMIO window tag default, the register offset map inside the
// window, STATUS/CTRL bit positions and the read-path source selector.
package dmem_mmio_bridge_pkg;

  // Upper address nibble that selects the MMIO window.
  localparam logic [3:0] MMIO_TAG_DEFAULT = 4'hF;

  // Word offsets inside the window (cpu_addr[5:0]).
  localparam logic [5:0] OFF_OUT     = 6'h00;  // OUT[k] at OFF_OUT + k
  localparam logic [5:0] OFF_IN      = 6'h10;  // IN[k]  at OFF_IN  + k
  localparam logic [5:0] OFF_COUNT   = 6'h20;
  localparam logic [5:0] OFF_COMPARE = 6'h21;
  localparam logic [5:0] OFF_STATUS  = 6'h22;
  localparam logic [5:0] OFF_CTRL    = 6'h23;

  // STATUS / CTRL bit positions.
  localparam int STATUS_MATCH_BIT = 0;
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;

  // Which source drives cpu_rdata in the cycle after an access.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,  // nothing issued since reset: return 0
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } rdSelT;

endpackage

// File: rtl/dmem_mmio_bridge_sync.sv
// mmio_sync: multi-flop synchroniser for a vector of asynchronous inputs.
// Each bit is sampled independently; there is no cross-bit coherence, so
// software should only rely on values that are held stable.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset, clears every stage
//   d      - asynchronous input vector
//   q      - synchronised output, STAGES edges behind d
module mmio_sync
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would collapse
  // the chain into a single flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: sits between the processor data port and the data RAM.
// Addresses whose top nibble equals MMIO_TAG hit a bank of I/O registers
// (OUT, synchronised IN, COUNT/COMPARE timer, STATUS, CTRL); everything else
// passes straight to the RAM. MMIO reads are registered so both targets
// return data one cycle after the address.
// Ports:
//   clock, reset          - system clock, asynchronous active-low reset
//   cpu_addr/wdata/wren   - processor data-memory request
//   cpu_rdata             - read data, valid the cycle after the address
//   ram_addr/wdata/wren   - RAM request (write suppressed for MMIO hits)
//   ram_rdata             - synchronous RAM read data (1-cycle latency)
//   gpio_out              - OUT registers, register k at [k*DATA_W +: DATA_W]
//   gpio_in               - asynchronous inputs, same flattening
//   test_out              - bit 0 of OUT[0]
//   timer_irq             - STATUS.match & CTRL.irq_en
module dmem_mmio_bridge
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int         ADDR_W      = 12,
  parameter int         DATA_W      = 32,
  parameter int         N_OUT       = 4,
  parameter int         N_IN        = 4,
  parameter logic [3:0] MMIO_TAG    = MMIO_TAG_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_wren,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic                    ram_wren,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [N_OUT*DATA_W-1:0] gpio_out,
  input  logic [N_IN*DATA_W-1:0]  gpio_in,
  output logic                    test_out,
  output logic                    timer_irq
);

  // ---------------------------------------------------------------- decode
  logic       mmioHit;
  logic       mmioWr;
  logic [5:0] offset;
  logic       wrCount, wrCompare, wrStatus, wrCtrl;

  assign mmioHit   = (cpu_addr[ADDR_W-1 -: 4] == MMIO_TAG);
  assign mmioWr    = cpu_wren & mmioHit;
  assign offset    = cpu_addr[5:0];
  assign wrCount   = mmioWr && (offset == OFF_COUNT);
  assign wrCompare = mmioWr && (offset == OFF_COMPARE);
  assign wrStatus  = mmioWr && (offset == OFF_STATUS);
  assign wrCtrl    = mmioWr && (offset == OFF_CTRL);

  // Address bits between the offset and the tag alias the window.
  logic unusedAddrBits;
  assign unusedAddrBits = ^cpu_addr[ADDR_W-5:6];

  // ------------------------------------------------------------ RAM side
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_wren  = cpu_wren & ~mmioHit;

  // ------------------------------------------------------- OUT registers
  logic [N_OUT-1:0][DATA_W-1:0] outReg;

  // NOTE: the OUT bank is software-visible architectural state, so unlike a
  // RAM array every word is a reset flop; this keeps gpio_out at 0 out of
  // reset instead of driving pins with garbage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outReg <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (mmioWr && (offset == OFF_OUT + 6'(k))) outReg[k] <= cpu_wdata;
      end
    end
  end

  assign gpio_out = outReg;
  assign test_out = outReg[0][0];

  // -------------------------------------------------- input synchronisers
  logic [N_IN-1:0][DATA_W-1:0] inSync;

  for (genvar k = 0; k < N_IN; k++) begin : gInSync
    mmio_sync #(
      .WIDTH (DATA_W),
      .STAGES(SYNC_STAGES)
    ) uSync (
      .clock(clock),
      .reset(reset),
      .d    (gpio_in[k*DATA_W +: DATA_W]),
      .q    (inSync[k])
    );
  end

  // ----------------------------------------------------------------- timer
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] compare;
  logic              match;
  logic              ctrlEn;
  logic              ctrlIrqEn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      compare   <= '0;
      match     <= 1'b0;
      ctrlEn    <= 1'b0;
      ctrlIrqEn <= 1'b0;
    end else begin
      // A software write to COUNT takes priority over the free-running
      // increment; the increment wraps silently.
      if (wrCount)     count <= cpu_wdata;
      else if (ctrlEn) count <= count + DATA_W'(1);

      if (wrCompare) compare <= cpu_wdata;

      // Set beats write-1-to-clear so a match landing on the clear is kept.
      if (ctrlEn && (count == compare))                    match <= 1'b1;
      else if (wrStatus && cpu_wdata[STATUS_MATCH_BIT])    match <= 1'b0;

      if (wrCtrl) begin
        ctrlEn    <= cpu_wdata[CTRL_EN_BIT];
        ctrlIrqEn <= cpu_wdata[CTRL_IRQ_EN_BIT];
      end
    end
  end

  assign timer_irq = match & ctrlIrqEn;

  // ------------------------------------------------------------ read path
  logic [DATA_W-1:0] rdVal;

  // NOTE: rdVal gets a default before any conditional assignment so every
  // unmapped offset reads 0 and the block stays purely combinational.
  always_comb begin
    rdVal = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (offset == OFF_OUT + 6'(k)) rdVal = outReg[k];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (offset == OFF_IN + 6'(k)) rdVal = inSync[k];
    end
    case (offset)
      OFF_COUNT:   rdVal = count;
      OFF_COMPARE: rdVal = compare;
      OFF_STATUS:  rdVal[STATUS_MATCH_BIT] = match;
      OFF_CTRL: begin
        rdVal[CTRL_EN_BIT]     = ctrlEn;
        rdVal[CTRL_IRQ_EN_BIT] = ctrlIrqEn;
      end
      default: ;
    endcase
  end

  // Registering the pre-edge register value gives the RAM's 1-cycle latency
  // and makes a same-cycle read return the value before the write.
  rdSelT             rdSelQ;
  logic [DATA_W-1:0] mmioRdQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdSelQ  <= SEL_NONE;
      mmioRdQ <= '0;
    end else begin
      rdSelQ  <= mmioHit ? SEL_MMIO : SEL_RAM;
      mmioRdQ <= rdVal;
    end
  end

  // SEL_NONE only exists between reset and the first edge, so cpu_rdata is
  // 0 under reset regardless of what the RAM is driving.
  always_comb begin
    case (rdSelQ)
      SEL_MMIO: cpu_rdata = mmioRdQ;
      SEL_RAM:  cpu_rdata = ram_rdata;
      default:  cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge with a behavioural synchronous
// RAM behind the bridge. Read data expectations go into a scoreboard queue
// when an access is driven and are compared one cycle later.
module tb_dmem_mmio_bridge;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_wren;
  logic [31:0]   cpu_rdata;
  logic [11:0]   ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_wren;
  logic [31:0]   ram_rdata;
  logic [127:0]  gpio_out;
  logic [127:0]  gpio_in;
  logic          test_out;
  logic          timer_irq;

  dmem_mmio_bridge dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_wren (cpu_wren),
    .cpu_rdata(cpu_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wren (ram_wren),
    .ram_rdata(ram_rdata),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .test_out (test_out),
    .timer_irq(timer_irq)
  );

  always #5 clock = ~clock;

  // Synchronous RAM model, 1-cycle read latency, read-before-write.
  logic [31:0] mem [4096];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int nVec = 0;
  int nErr = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] exp;
  } sbT;
  sbT sb[$];

  // Wait for the next falling edge and retire the oldest pending read.
  task automatic cycle();
    sbT e;
    @(negedge clock);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) check(e.name, {96'h0, cpu_rdata}, {96'h0, e.exp});
    end
  endtask

  task automatic drive(input logic [11:0] addr, input logic [31:0] wdata,
                       input logic wren, input logic chk,
                       input logic [31:0] exp, input logic expRamWren);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wren  = wren;
    sb.push_back('{$sformatf("rdata@%h", addr), chk, exp});
    #1;
    check($sformatf("ramPort@%h", addr), {83'h0, ram_wren, ram_addr, ram_wdata},
          {83'h0, expRamWren, addr, wdata});
  endtask

  // Hand-written MMIO step: check timer_irq after the last edge, then drive.
  task automatic stepIrq(input logic [11:0] addr, input logic [31:0] wdata,
                         input logic wren, input logic chk,
                         input logic [31:0] exp, input logic expIrq);
    cycle();
    check("timerIrq", {127'h0, timer_irq}, {127'h0, expIrq});
    drive(addr, wdata, wren, chk, exp, 1'b0);
  endtask

  typedef struct {
    logic [11:0]  addr;
    logic [31:0]  wdata;
    logic         wren;
    logic         chk;
    logic [31:0]  exp;
    logic         ramWren;
    logic [127:0] gpioIn;
  } vecT;

  localparam logic [127:0] G0 = 128'h0;
  localparam logic [127:0] G1 = {32'h1357_9BDF, 64'h0, 32'hA5A5_A5A5};

  vecT vecs [24];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{12'hF01, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0,         1'b0, G0};
    vecs[1]  = '{12'hF01, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, G0};
    vecs[2]  = '{12'h010, 32'h1234,      1'b1, 1'b0, 32'h0,         1'b1, G0};
    vecs[3]  = '{12'h010, 32'h0,         1'b0, 1'b1, 32'h1234,      1'b0, G0};
    vecs[4]  = '{12'hF41, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, G0};
    vecs[5]  = '{12'hF00, 32'h5,         1'b1, 1'b1, 32'h0,         1'b0, G0};
    vecs[6]  = '{12'hF00, 32'h9,         1'b1, 1'b1, 32'h5,         1'b0, G0};
    vecs[7]  = '{12'hF00, 32'h0,         1'b0, 1'b1, 32'h9,         1'b0, G0};
    vecs[8]  = '{12'hF3F, 32'h123,       1'b1, 1'b1, 32'h0,         1'b0, G0};
    vecs[9]  = '{12'hF3F, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, G0};
    vecs[10] = '{12'hF04, 32'hFFFF,      1'b1, 1'b1, 32'h0,         1'b0, G0};
    vecs[11] = '{12'hF04, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, G0};
    vecs[12] = '{12'hF21, 32'h77,        1'b1, 1'b1, 32'h0,         1'b0, G0};
    vecs[13] = '{12'hF21, 32'h0,         1'b0, 1'b1, 32'h77,        1'b0, G0};
    vecs[14] = '{12'h701, 32'hCAFE,      1'b1, 1'b0, 32'h0,         1'b1, G0};
    vecs[15] = '{12'hF01, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, G0};
    vecs[16] = '{12'h701, 32'h0,         1'b0, 1'b1, 32'hCAFE,      1'b0, G0};
    vecs[17] = '{12'hF10, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, G1};
    vecs[18] = '{12'hF10, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, G1};
    vecs[19] = '{12'hF10, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, G1};
    vecs[20] = '{12'hF10, 32'h0,         1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, G1};
    vecs[21] = '{12'hF10, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, G1};
    vecs[22] = '{12'hF13, 32'h0,         1'b0, 1'b1, 32'h1357_9BDF, 1'b0, G1};
    vecs[23] = '{12'hF14, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, G1};

    // Reset state.
    reset     = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_wren  = 1'b0;
    gpio_in   = '0;
    #1;
    check("resetOutputs", {94'h0, cpu_rdata, test_out, timer_irq},
          {94'h0, 32'h0, 1'b0, 1'b0});
    check("resetGpioOut", gpio_out, 128'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Table-driven accesses.
    for (int i = 0; i < 24; i++) begin
      cycle();
      gpio_in = vecs[i].gpioIn;
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].wren, vecs[i].chk,
            vecs[i].exp, vecs[i].ramWren);
    end
    check("gpioOut", gpio_out, {64'h0, 32'hDEAD_BEEF, 32'h9});
    check("testOut", {127'h0, test_out}, 128'h1);

    // Timer: COMPARE=5, COUNT=0, CTRL=3; match lands on edge C+6.
    stepIrq(12'hF21, 32'h5, 1'b1, 1'b0, 32'h0, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    stepIrq(12'hF23, 32'h3, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'(k), (k >= 6));
    end
    stepIrq(12'hF22, 32'h0, 1'b1, 1'b1, 32'h1, 1'b1);  // write 0: no effect
    stepIrq(12'hF22, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1);
    stepIrq(12'hF22, 32'h1, 1'b1, 1'b1, 32'h1, 1'b1);  // clear
    stepIrq(12'hF22, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    // Clear coinciding with a new match: set wins.
    stepIrq(12'hF20, 32'h3, 1'b1, 1'b0, 32'h0, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h3, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    stepIrq(12'hF22, 32'h1, 1'b1, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF22, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1);
    stepIrq(12'hF22, 32'h1, 1'b1, 1'b1, 32'h1, 1'b1);
    // irq_en off: match still sets, timer_irq stays low.
    stepIrq(12'hF23, 32'h1, 1'b1, 1'b1, 32'h3, 1'b0);
    stepIrq(12'hF20, 32'h5, 1'b1, 1'b0, 32'h0, 1'b0);
    stepIrq(12'hF22, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF22, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
    // Wrap, then a COUNT write in the wrap cycle.
    stepIrq(12'hF20, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
    stepIrq(12'hF20, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    stepIrq(12'hF20, 32'h100, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h101, 1'b0);

    // Mid-run asynchronous reset with OUT[0]=5 and the timer running.
    stepIrq(12'hF00, 32'h5, 1'b1, 1'b1, 32'h9, 1'b0);
    stepIrq(12'hF23, 32'h3, 1'b1, 1'b1, 32'h1, 1'b0);
    stepIrq(12'hF00, 32'h0, 1'b0, 1'b1, 32'h5, 1'b1);
    cycle();
    check("preResetOut0", {96'h0, gpio_out[31:0]}, 128'h5);
    cpu_addr = '0;
    cpu_wren = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("asyncResetOutputs", {94'h0, cpu_rdata, test_out, timer_irq},
          {94'h0, 32'h0, 1'b0, 1'b0});
    check("asyncResetGpioOut", gpio_out, 128'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF22, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF23, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'hF20, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    stepIrq(12'h701, 32'h0, 1'b0, 1'b1, 32'hCAFE, 1'b0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
